// File: rtl/if_stage_pipe_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction memory port and IF/ID outputs.
// The slave modport is the fetch stage; the master modport is its environment.
interface if_stage_pipe_if;
  logic        stall;
  logic        IF_flush;
  logic        jump;
  logic        bne;
  logic        jr;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic [31:0] jr_target;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;

  modport master (
    output stall, IF_flush, jump, bne, jr,
    output jump_target, branch_target, jr_target, imem_rdata,
    input  imem_addr, if_id_instr, if_id_pc4, if_id_valid
  );

  modport slave (
    input  stall, IF_flush, jump, bne, jr,
    input  jump_target, branch_target, jr_target, imem_rdata,
    output imem_addr, if_id_instr, if_id_pc4, if_id_valid
  );
endinterface

// File: rtl/if_stage_pipe.sv
// MIPS instruction-fetch stage: PC register, next-PC select, IF/ID register and
// a saturating counter of flushed fetch slots.
module if_stage_pipe #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0000,
  parameter int unsigned FLUSH_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cnt_clr,
  if_stage_pipe_if.slave         bus,
  output logic [FLUSH_CNT_W-1:0] flush_count
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic [31:0] redirect_target;
  logic        redirect;
  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic        valid_q;

  assign pc_plus4 = pc + 32'd4;
  assign redirect = bus.jr | bus.bne | bus.jump;

  always_comb begin
    redirect_target = bus.jump_target;
    if (bus.jr) begin
      redirect_target = bus.jr_target;
    end else if (bus.bne) begin
      redirect_target = bus.branch_target;
    end
  end

  // A redirect must never be lost to a stall, so it is checked first.
  always_comb begin
    pc_next = pc_plus4;
    if (redirect) begin
      pc_next = redirect_target & 32'hFFFF_FFFC;
    end else if (bus.stall) begin
      pc_next = pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (bus.IF_flush) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= pc_plus4;
      valid_q <= 1'b0;
    end else if (!bus.stall) begin
      instr_q <= bus.imem_rdata;
      pc4_q   <= pc_plus4;
      valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_count <= '0;
    end else if (cnt_clr) begin
      flush_count <= '0;
    end else if (bus.IF_flush && (flush_count != '1)) begin
      flush_count <= flush_count + FLUSH_CNT_W'(1);
    end
  end

  assign bus.imem_addr   = pc;
  assign bus.if_id_instr = instr_q;
  assign bus.if_id_pc4   = pc4_q;
  assign bus.if_id_valid = valid_q;

endmodule

// File: tb/tb_if_stage_pipe.sv
// Randomized and directed bench for if_stage_pipe against a behavioural fetch model.
module tb_if_stage_pipe;
  localparam logic [31:0] RESET_PC = 32'h0000_0400;
  localparam logic [31:0] NOP      = 32'h1357_9BDF;
  localparam int unsigned CW       = 4;
  localparam int unsigned CNT_MAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] flush_count;

  if_stage_pipe_if bus ();

  if_stage_pipe #(
    .RESET_PC   (RESET_PC),
    .NOP_INSTR  (NOP),
    .FLUSH_CNT_W(CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cnt_clr    (cnt_clr),
    .bus        (bus),
    .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 1'b0;
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  int unsigned m_cnt;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_instr = NOP; m_pc4 = 32'd0; m_valid = 1'b0; m_cnt = 0;
  endtask

  task automatic idle();
    bus.stall = 0; bus.IF_flush = 0; bus.jump = 0; bus.bne = 0; bus.jr = 0; cnt_clr = 0;
  endtask

  // One clock: work out what the fetch stage must hold after the edge from the
  // current inputs, then advance time to just past the edge.
  task automatic cyc();
    logic [31:0] n_pc, n_instr, n_pc4, tgt;
    logic        n_valid;
    int unsigned n_cnt;
    n_pc = m_pc; n_instr = m_instr; n_pc4 = m_pc4; n_valid = m_valid; n_cnt = m_cnt;
    if (bus.jr || bus.bne || bus.jump) begin
      tgt  = bus.jr ? bus.jr_target : (bus.bne ? bus.branch_target : bus.jump_target);
      n_pc = (tgt / 4) * 4;
    end else if (!bus.stall) begin
      n_pc = m_pc + 32'd4;
    end
    if (bus.IF_flush) begin
      n_instr = NOP; n_pc4 = m_pc + 32'd4; n_valid = 1'b0;
    end else if (!bus.stall) begin
      n_instr = mem_word(m_pc); n_pc4 = m_pc + 32'd4; n_valid = 1'b1;
    end
    if (cnt_clr) n_cnt = 0;
    else if (bus.IF_flush) n_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
    @(posedge clk);
    if (rst_n) begin
      m_pc = n_pc; m_instr = n_instr; m_pc4 = n_pc4; m_valid = n_valid; m_cnt = n_cnt;
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_addr", bus.imem_addr, m_pc);
      check("if_id_instr", bus.if_id_instr, m_instr);
      check("if_id_pc4", bus.if_id_pc4, m_pc4);
      check("if_id_valid", {31'd0, bus.if_id_valid}, {31'd0, m_valid});
      check("flush_count", {28'd0, flush_count}, m_cnt);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 1000000", $time);
    $fatal(1);
  end

  initial begin
    idle();
    bus.jump_target = '0; bus.branch_target = '0; bus.jr_target = '0;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    check("rst_imem_addr", bus.imem_addr, 32'h0000_0400);
    check("rst_valid", {31'd0, bus.if_id_valid}, 32'd0);
    check("rst_count", {28'd0, flush_count}, 32'd0);
    check("rst_instr", bus.if_id_instr, 32'h1357_9BDF);
    chk_en = 1'b1;
    @(negedge clk); #1 rst_n = 1'b1;

    // Release and free-run three clocks.
    cyc(); check("run1_addr", bus.imem_addr, 32'h404); check("run1_pc4", bus.if_id_pc4, 32'h404);
    check("run1_instr", bus.if_id_instr, mem_word(32'h400));
    cyc(); check("run2_addr", bus.imem_addr, 32'h408); check("run2_pc4", bus.if_id_pc4, 32'h408);
    cyc(); check("run3_addr", bus.imem_addr, 32'h40C); check("run3_pc4", bus.if_id_pc4, 32'h40C);

    // Unflushed jump to 0x10, then stall two cycles.
    bus.jump = 1; bus.jump_target = 32'h10; cyc(); idle();
    check("jmp_addr", bus.imem_addr, 32'h10); check("jmp_valid", {31'd0, bus.if_id_valid}, 32'd1);
    bus.stall = 1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("stall_addr", bus.imem_addr, 32'h10);
      check("stall_pc4", bus.if_id_pc4, 32'h410);
      check("stall_instr", bus.if_id_instr, mem_word(32'h40C));
    end
    idle(); cyc(); check("unstall_addr", bus.imem_addr, 32'h14);

    // Taken bne at pc=0x20.
    bus.jump = 1; bus.jump_target = 32'h20; cyc(); idle();
    bus.bne = 1; bus.IF_flush = 1; bus.branch_target = 32'h80; cyc(); idle();
    check("bne_addr", bus.imem_addr, 32'h80);
    check("bne_instr", bus.if_id_instr, 32'h1357_9BDF);
    check("bne_valid", {31'd0, bus.if_id_valid}, 32'd0);
    check("bne_count", {28'd0, flush_count}, 32'd1);
    cyc();
    check("bne_next_instr", bus.if_id_instr, mem_word(32'h80));
    check("bne_next_valid", {31'd0, bus.if_id_valid}, 32'd1);
    check("bne_next_pc4", bus.if_id_pc4, 32'h84);

    // All three redirects at once, then redirect while stalled.
    bus.jump = 1; bus.bne = 1; bus.jr = 1; bus.IF_flush = 1;
    bus.jump_target = 32'h100; bus.branch_target = 32'h200; bus.jr_target = 32'h303;
    cyc(); idle();
    check("prio_addr", bus.imem_addr, 32'h300);
    bus.jump = 1; bus.stall = 1; bus.IF_flush = 1; bus.jump_target = 32'h500; cyc(); idle();
    check("stall_redir_addr", bus.imem_addr, 32'h500);
    check("stall_redir_valid", {31'd0, bus.if_id_valid}, 32'd0);
    check("stall_redir_pc4", bus.if_id_pc4, 32'h304);

    // PC wrap.
    bus.jump = 1; bus.jump_target = 32'hFFFF_FFFF; cyc(); idle();
    check("wrap_top", bus.imem_addr, 32'hFFFF_FFFC);
    cyc();
    check("wrap_addr", bus.imem_addr, 32'h0);
    check("wrap_pc4", bus.if_id_pc4, 32'h0);

    // Counter saturation and clear-beats-increment.
    cnt_clr = 1; cyc(); idle();
    bus.IF_flush = 1;
    for (int i = 0; i < 20; i++) cyc();
    check("sat_count", {28'd0, flush_count}, 32'd15);
    cnt_clr = 1; cyc(); idle();
    check("clr_count", {28'd0, flush_count}, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bus.jump = ($urandom_range(0, 99) < 8);
      bus.bne  = ($urandom_range(0, 99) < 8);
      bus.jr   = ($urandom_range(0, 99) < 6);
      bus.jump_target = $urandom; bus.branch_target = $urandom; bus.jr_target = $urandom;
      bus.IF_flush = (bus.jump || bus.bne || bus.jr) ? ($urandom_range(0, 9) != 0)
                                                     : ($urandom_range(0, 9) == 0);
      bus.stall = ($urandom_range(0, 4) == 0);
      cnt_clr   = ($urandom_range(0, 39) == 0);
      cyc();
    end
    idle();

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_addr", bus.imem_addr, 32'h400);
    check("arst_instr", bus.if_id_instr, 32'h1357_9BDF);
    check("arst_pc4", bus.if_id_pc4, 32'h0);
    check("arst_valid", {31'd0, bus.if_id_valid}, 32'd0);
    check("arst_count", {28'd0, flush_count}, 32'd0);
    cyc();
    @(negedge clk); #1 rst_n = 1'b1;
    cyc(); check("post_arst_addr", bus.imem_addr, 32'h404);
    cyc();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
